// File: rtl/bp_update_scheduler_pkg.sv
// Shared types for the branch-predictor update path: queued update record and scheduler states.
// No logic; no latency.
// No flow control of its own.
package rv32i_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [1:0]  counter;
  } bp_update_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } bp_sched_state_t;

endpackage

// File: rtl/bp_update_scheduler_fifo.sv
// Circular buffer of pending predictor updates, head exposed combinationally.
// Latency: a push is visible at the head one cycle later. Push/pop may occur in the same cycle.
// Backpressure: the caller must not push when count==DEPTH or pop when empty.
module bp_update_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  bp_update_t               i_push_dat,
  input  logic                     i_pop,
  output bp_update_t               o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  bp_update_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/bp_update_scheduler.sv
// Queues resolved-branch updates and writes them into the single-ported predictor table when IF is idle.
// Latency: an accepted update can be written the following cycle at the earliest. Optional starve forcing: BP_UPD_STARVE_EN.
// Backpressure: upd_ready low while the queue is full; IF lookups are denied while a forced drain runs.
module bp_update_scheduler
  import rv32i_types::*;
#(
  parameter int s_index      = 10,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   upd_valid,
  input  logic [31:0]            upd_pc,
  input  logic [31:0]            upd_target,
  input  logic [1:0]             upd_counter,
  output logic                   upd_ready,
  input  logic                   if_lookup_req,
  output logic                   if_lookup_gnt,
  output logic                   tbl_we,
  output logic [s_index-1:0]     tbl_windex,
  output logic [31:0]            tbl_wtag,
  output logic [31:0]            tbl_wtarget,
  output logic [1:0]             tbl_wcounter,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  bp_sched_state_t  r_state;
  bp_sched_state_t  w_state_next;
  bp_update_t       w_push_dat;
  bp_update_t       w_head;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_next;
  logic             w_push;
  logic             w_empty;
  logic             w_write_slot;
  logic             w_starve_hit;

  assign w_push_dat = '{pc: upd_pc, target: upd_target, counter: upd_counter};
  assign upd_ready  = (w_count < CNT_W'(DEPTH));
  assign w_push     = upd_valid && upd_ready;
  assign w_empty    = (w_count == '0);
  assign w_write_slot = !w_empty && (!if_lookup_req || (r_state == FORCE));

  always_comb begin
    w_count_next = w_count;
    case ({w_push, w_write_slot})
      2'b10:   w_count_next = w_count + CNT_W'(1);
      2'b01:   w_count_next = w_count - CNT_W'(1);
      default: w_count_next = w_count;
    endcase
  end

  bp_update_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_write_slot),
    .o_head     (w_head),
    .o_count    (w_count)
  );

`ifdef BP_UPD_STARVE_EN
  localparam int ST_W = $clog2(STARVE_LIMIT) + 1;

  logic [ST_W-1:0] r_starve;
  logic [ST_W-1:0] w_starve_next;

  always_comb begin
    w_starve_next = r_starve;
    if (w_empty || w_write_slot) begin
      w_starve_next = '0;
    end else if (r_starve != ST_W'(STARVE_LIMIT)) begin
      w_starve_next = r_starve + ST_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_starve <= '0;
    else      r_starve <= w_starve_next;
  end

  // Forcing takes effect on the edge where the count reaches the limit.
  assign w_starve_hit = (w_starve_next == ST_W'(STARVE_LIMIT));
`else
  // Without the starve counter only a full queue forces a drain; a zero limit is not a legal setting.
  assign w_starve_hit = (STARVE_LIMIT == 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_push) w_state_next = PEND;
      end
      PEND: begin
        if (w_count_next == '0)
          w_state_next = IDLE;
        else if ((w_count_next == CNT_W'(DEPTH)) || w_starve_hit)
          w_state_next = FORCE;
      end
      FORCE: begin
        if (w_count_next == '0)
          w_state_next = IDLE;
        else if (w_count_next <= CNT_W'(DEPTH / 2))
          w_state_next = PEND;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    tbl_we        = w_write_slot;
    if_lookup_gnt = if_lookup_req && !w_write_slot;
    tbl_windex    = '0;
    tbl_wtag      = '0;
    tbl_wtarget   = '0;
    tbl_wcounter  = '0;
    if (w_write_slot) begin
      tbl_windex   = w_head.pc[s_index+1:2];
      tbl_wtag     = w_head.pc;
      tbl_wtarget  = w_head.target;
      tbl_wcounter = w_head.counter;
    end
  end

  assign q_count = w_count;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler at DEPTH=4, STARVE_LIMIT=8, s_index=10.
module tb_bp_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic [1:0]  upd_counter;
  logic        upd_ready;
  logic        if_lookup_req;
  logic        if_lookup_gnt;
  logic        tbl_we;
  logic [9:0]  tbl_windex;
  logic [31:0] tbl_wtag;
  logic [31:0] tbl_wtarget;
  logic [1:0]  tbl_wcounter;
  logic [2:0]  q_count;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_tag;
  logic        exp_we;

  bp_update_scheduler #(
    .s_index      (10),
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .upd_counter   (upd_counter),
    .upd_ready     (upd_ready),
    .if_lookup_req (if_lookup_req),
    .if_lookup_gnt (if_lookup_gnt),
    .tbl_we        (tbl_we),
    .tbl_windex    (tbl_windex),
    .tbl_wtag      (tbl_wtag),
    .tbl_wtarget   (tbl_wtarget),
    .tbl_wcounter  (tbl_wcounter),
    .q_count       (q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] ctr);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_target  = tgt;
    upd_counter = ctr;
  endtask

  initial begin
    rst = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_counter = '0;
    if_lookup_req = 1'b1;
    #3;
    chk("rst_we", 32'(tbl_we), 32'd0);
    chk("rst_qcount", 32'(q_count), 32'd0);
    chk("rst_ready", 32'(upd_ready), 32'd1);
    chk("rst_gnt", 32'(if_lookup_gnt), 32'd1);
    chk("rst_wtag", tbl_wtag, 32'd0);
    chk("rst_windex", 32'(tbl_windex), 32'd0);
    tick();
    rst = 1'b1; if_lookup_req = 1'b0;

    // single update, no lookups
    drive_upd(32'h40, 32'h80, 2'b11);
    settle();
    chk("single_no_passthru", 32'(tbl_we), 32'd0);
    tick();
    upd_valid = 1'b0;
    settle();
    chk("single_we", 32'(tbl_we), 32'd1);
    chk("single_windex", 32'(tbl_windex), 32'h010);
    chk("single_wtag", tbl_wtag, 32'h40);
    chk("single_wtarget", tbl_wtarget, 32'h80);
    chk("single_wcounter", 32'(tbl_wcounter), 32'd3);
    chk("single_qcount", 32'(q_count), 32'd1);
    tick();
    settle();
    chk("single_drained", 32'(q_count), 32'd0);
    chk("single_idle_we", 32'(tbl_we), 32'd0);

    // lookup priority over a single queued entry
    if_lookup_req = 1'b1;
    drive_upd(32'h100, 32'h104, 2'b01);
    settle();
    chk("prio_gnt_empty", 32'(if_lookup_gnt), 32'd1);
    tick();
    upd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("prio_gnt", 32'(if_lookup_gnt), 32'd1);
      chk("prio_we", 32'(tbl_we), 32'd0);
      chk("prio_qcount", 32'(q_count), 32'd1);
      tick();
    end
    if_lookup_req = 1'b0;
    settle();
    chk("prio_write", 32'(tbl_we), 32'd1);
    chk("prio_windex", 32'(tbl_windex), 32'h040);
    tick();
    settle();
    chk("prio_drained", 32'(q_count), 32'd0);

    // fill under continuous lookups -> forced drain of two entries
    if_lookup_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_upd(32'h200 + 32'(4 * k), 32'h1000 + 32'(k), 2'(k));
      sb.push_back(32'h200 + 32'(4 * k));
      settle();
      chk("fill_ready", 32'(upd_ready), 32'd1);
      chk("fill_we", 32'(tbl_we), 32'd0);
      tick();
    end
    drive_upd(32'h9999_0000, 32'h0, 2'b00);
    settle();
    exp_tag = sb.pop_front();
    chk("full_qcount", 32'(q_count), 32'd4);
    chk("full_ready", 32'(upd_ready), 32'd0);
    chk("force1_we", 32'(tbl_we), 32'd1);
    chk("force1_gnt", 32'(if_lookup_gnt), 32'd0);
    chk("force1_windex", 32'(tbl_windex), 32'h080);
    chk("force1_wtag", tbl_wtag, exp_tag);
    tick();
    upd_valid = 1'b0;
    settle();
    exp_tag = sb.pop_front();
    chk("force2_qcount", 32'(q_count), 32'd3);
    chk("force2_we", 32'(tbl_we), 32'd1);
    chk("force2_gnt", 32'(if_lookup_gnt), 32'd0);
    chk("force2_wtag", tbl_wtag, exp_tag);
    chk("force2_wtarget", tbl_wtarget, 32'h1001);
    tick();
    settle();
    chk("pend_qcount", 32'(q_count), 32'd2);
    chk("pend_we", 32'(tbl_we), 32'd0);
    chk("pend_gnt", 32'(if_lookup_gnt), 32'd1);

    // simultaneous push/pop at count 2, order checked against scoreboard
    if_lookup_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_upd(32'h300 + 32'(4 * k), 32'h2000, 2'b10);
      settle();
      exp_tag = sb.pop_front();
      chk("pp_we", 32'(tbl_we), 32'd1);
      chk("pp_wtag", tbl_wtag, exp_tag);
      chk("pp_qcount", 32'(q_count), 32'd2);
      sb.push_back(32'h300 + 32'(4 * k));
      tick();
    end
    upd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      exp_tag = sb.pop_front();
      chk("pp_drain_wtag", tbl_wtag, exp_tag);
      chk("pp_drain_qcount", 32'(q_count), 32'(2 - k));
      tick();
    end
    settle();
    chk("pp_empty", 32'(q_count), 32'd0);

    // starvation: one entry under continuous lookups
    if_lookup_req = 1'b1;
    drive_upd(32'h400, 32'h404, 2'b01);
    tick();
    upd_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      settle();
`ifdef BP_UPD_STARVE_EN
      exp_we = (i == 9);
`else
      exp_we = 1'b0;
`endif
      chk("starve_we", 32'(tbl_we), 32'(exp_we));
      chk("starve_gnt", 32'(if_lookup_gnt), 32'(!exp_we));
      tick();
    end
    if_lookup_req = 1'b0;
    settle();
`ifdef BP_UPD_STARVE_EN
    chk("starve_after_we", 32'(tbl_we), 32'd0);
`else
    chk("starve_release_we", 32'(tbl_we), 32'd1);
    chk("starve_release_windex", 32'(tbl_windex), 32'h100);
`endif
    tick();
    settle();
    chk("starve_empty", 32'(q_count), 32'd0);

    // reset in the middle of a forced drain
    if_lookup_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_upd(32'h600 + 32'(4 * k), 32'h3000, 2'b11);
      tick();
    end
    upd_valid = 1'b0;
    settle();
    chk("rf_full_we", 32'(tbl_we), 32'd1);
    tick();
    settle();
    chk("rf_qcount3", 32'(q_count), 32'd3);
    chk("rf_force_we", 32'(tbl_we), 32'd1);
    rst = 1'b0;
    settle();
    chk("rf_we", 32'(tbl_we), 32'd0);
    chk("rf_qcount", 32'(q_count), 32'd0);
    chk("rf_ready", 32'(upd_ready), 32'd1);
    chk("rf_gnt", 32'(if_lookup_gnt), 32'd1);
    chk("rf_wtag", tbl_wtag, 32'd0);
    chk("rf_wcounter", 32'(tbl_wcounter), 32'd0);
    tick();
    rst = 1'b1;
    if_lookup_req = 1'b0;
    drive_upd(32'h500, 32'h504, 2'b10);
    settle();
    chk("post_rst_no_passthru", 32'(tbl_we), 32'd0);
    tick();
    upd_valid = 1'b0;
    settle();
    chk("post_rst_we", 32'(tbl_we), 32'd1);
    chk("post_rst_windex", 32'(tbl_windex), 32'h140);
    chk("post_rst_wtarget", tbl_wtarget, 32'h504);
    chk("post_rst_wcounter", 32'(tbl_wcounter), 32'd2);
    tick();
    settle();
    chk("post_rst_empty", 32'(q_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
